// File: rtl/wfg_drive_pat_core.sv
// Pattern driver core: on each selected-core sync it fetches one stream word
// and updates the registered pattern pins according to per-pin mode selects.
module wfg_drive_pat_core #(
    parameter int CHANNELS = 32,
    parameter int AXIS_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          wfg_core_sync_i,
    input  logic [AXIS_W-1:0]   wfg_axis_tdata_i,
    input  logic                wfg_axis_tvalid_i,
    output logic                wfg_axis_tready_o,
    input  logic [31:0]         ctrl_en_q_i,
    input  logic                cfg_core_sel_q_i,
    input  logic [7:0]          cfg_begin_q_i,
    input  logic [7:0]          cfg_end_q_i,
    input  logic [31:0]         patsel0_low_q_i,
    input  logic [31:0]         patsel1_high_q_i,
    output logic [CHANNELS-1:0] wfg_pat_o,
    output logic                wfg_pat_missed_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                en;
    logic                sel_sync;
    logic                handshake;
    logic                clear;
    logic [CHANNELS-1:0] pat_next;
    logic                unused;

    assign en        = ctrl_en_q_i[0];
    assign sel_sync  = wfg_core_sync_i[cfg_core_sel_q_i];
    assign handshake = wfg_axis_tvalid_i & wfg_axis_tready_o;
    assign clear     = !en || (state == IDLE);
    assign unused    = ^ctrl_en_q_i[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = ARMED;
                ARMED:   if (sel_sync) state_next = FETCH;
                FETCH:   if (wfg_axis_tvalid_i) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        wfg_axis_tready_o = (state == FETCH);
    end

    // Pins outside [begin, end] are forced low; an inverted range clears all.
    always_comb begin
        pat_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [7:0] idx;
            logic [1:0] mode;
            idx  = 8'(i);
            mode = {patsel1_high_q_i[i], patsel0_low_q_i[i]};
            unique case (mode)
                2'b00: pat_next[i] = 1'b0;
                2'b01: pat_next[i] = 1'b1;
                2'b10: pat_next[i] = wfg_axis_tdata_i[i];
                2'b11: pat_next[i] = ~wfg_pat_o[i];
                default: pat_next[i] = 1'b0;
            endcase
            if (idx < cfg_begin_q_i || idx > cfg_end_q_i) begin
                pat_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfg_pat_o <= '0;
        end else if (clear) begin
            wfg_pat_o <= '0;
        end else if (handshake) begin
            wfg_pat_o <= pat_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfg_pat_missed_o <= 1'b0;
        end else if (clear) begin
            wfg_pat_missed_o <= 1'b0;
        end else if (state == FETCH && sel_sync) begin
            wfg_pat_missed_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wfg_drive_pat_core.sv
// Directed self-checking bench for wfg_drive_pat_core.
module tb_wfg_drive_pat_core;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sync;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [31:0] en;
    logic        core_sel;
    logic [7:0]  pbegin;
    logic [7:0]  pend;
    logic [31:0] patsel0;
    logic [31:0] patsel1;
    logic [31:0] pat;
    logic        missed;

    int errors = 0;
    int checks = 0;

    wfg_drive_pat_core #(.CHANNELS(32), .AXIS_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wfg_core_sync_i   (sync),
        .wfg_axis_tdata_i  (tdata),
        .wfg_axis_tvalid_i (tvalid),
        .wfg_axis_tready_o (tready),
        .ctrl_en_q_i       (en),
        .cfg_core_sel_q_i  (core_sel),
        .cfg_begin_q_i     (pbegin),
        .cfg_end_q_i       (pend),
        .patsel0_low_q_i   (patsel0),
        .patsel1_high_q_i  (patsel1),
        .wfg_pat_o         (pat),
        .wfg_pat_missed_o  (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq_exp [3];

    initial begin
        seq_exp[0] = 32'h000000F0;
        seq_exp[1] = 32'h00000000;
        seq_exp[2] = 32'h000000F0;

        rst_n = 1'b0; sync = 2'b00; tdata = '0; tvalid = 1'b0;
        en = '0; core_sel = 1'b0; pbegin = 8'd0; pend = 8'd31;
        patsel0 = 32'hFFFF0000; patsel1 = 32'h0000FFFF;
        #3;
        check("rst_pat", pat, 32'h0);
        check("rst_missed", {31'b0, missed}, 32'h0);
        check("rst_tready", {31'b0, tready}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // enable cycle: simultaneous sync must be ignored
        tdata = 32'hA5A5A5A5; tvalid = 1'b1;
        en = 32'h1; sync = 2'b01;
        tick();
        sync = 2'b00;
        check("en_cycle_tready", {31'b0, tready}, 32'h0);
        tick();
        check("armed_tready", {31'b0, tready}, 32'h0);

        // basic fetch with mixed modes
        sync = 2'b01;
        tick();
        sync = 2'b00;
        check("fetch_tready", {31'b0, tready}, 32'h1);
        check("fetch_pat_hold", pat, 32'h0);
        tick();
        check("basic_pat", pat, 32'hFFFFA5A5);
        check("basic_tready_off", {31'b0, tready}, 32'h0);

        // config changes between updates do not touch the pins
        patsel0 = 32'hFFFFFFFF; patsel1 = 32'hFFFFFFFF;
        pbegin = 8'd4; pend = 8'd7;
        tick();
        check("cfg_no_effect", pat, 32'hFFFFA5A5);

        en = 32'h0;
        tick();
        check("endrop_pat", pat, 32'h0);
        check("endrop_tready", {31'b0, tready}, 32'h0);
        en = 32'h1;
        tick();

        // toggle mode over pins 4..7
        for (int i = 0; i < 3; i++) begin
            sync = 2'b01;
            tick();
            sync = 2'b00;
            tick();
            check($sformatf("toggle_%0d", i), pat, seq_exp[i]);
        end
        check("toggle_missed", {31'b0, missed}, 32'h0);

        // stalled fetch with an extra sync inside the window
        patsel0 = 32'h0; patsel1 = 32'hFFFFFFFF;
        pbegin = 8'd0; pend = 8'd31;
        tvalid = 1'b0; tdata = 32'h12345678;
        sync = 2'b01;
        tick();
        sync = 2'b00;
        for (int k = 0; k < 10; k++) begin
            sync = (k == 3) ? 2'b01 : 2'b00;
            tick();
            check($sformatf("stall_tready_%0d", k), {31'b0, tready}, 32'h1);
            check($sformatf("stall_pat_%0d", k), pat, 32'h000000F0);
        end
        sync = 2'b00;
        check("stall_missed", {31'b0, missed}, 32'h1);
        tvalid = 1'b1;
        tick();
        check("stall_update", pat, 32'h12345678);
        check("stall_tready_off", {31'b0, tready}, 32'h0);
        tdata = 32'hDEADBEEF;
        tick();
        check("stall_single", pat, 32'h12345678);

        // core select: only core 1 counts
        core_sel = 1'b1; tdata = 32'h0F0F0F0F;
        sync = 2'b01;
        tick();
        sync = 2'b00;
        check("sel_core0_ign", {31'b0, tready}, 32'h0);
        tick();
        check("sel_core0_ign2", {31'b0, tready}, 32'h0);
        check("sel_pat_hold", pat, 32'h12345678);
        sync = 2'b10;
        tick();
        sync = 2'b00;
        check("sel_core1_tready", {31'b0, tready}, 32'h1);
        tick();
        check("sel_core1_pat", pat, 32'h0F0F0F0F);

        // inverted range clears every pin
        pbegin = 8'd10; pend = 8'd5; tdata = 32'hFFFFFFFF;
        sync = 2'b11;
        tick();
        sync = 2'b00;
        tick();
        check("inv_range", pat, 32'h0);

        // end beyond last channel
        pbegin = 8'd31; pend = 8'd200;
        sync = 2'b10;
        tick();
        sync = 2'b00;
        tick();
        check("wide_end", pat, 32'h80000000);

        // enable dropped mid-fetch
        tvalid = 1'b0;
        sync = 2'b10;
        tick();
        sync = 2'b00;
        check("endrop_fetch_tready", {31'b0, tready}, 32'h1);
        check("endrop_pre_missed", {31'b0, missed}, 32'h1);
        en = 32'h0;
        tick();
        check("endrop_f_tready", {31'b0, tready}, 32'h0);
        check("endrop_f_pat", pat, 32'h0);
        check("endrop_f_missed", {31'b0, missed}, 32'h0);
        en = 32'h1;
        tick();

        // reset pulsed mid-fetch
        pbegin = 8'd0; pend = 8'd31; tvalid = 1'b1;
        sync = 2'b10;
        tick();
        sync = 2'b00;
        tick();
        check("pre_rst_pat", pat, 32'hFFFFFFFF);
        tvalid = 1'b0;
        sync = 2'b10;
        tick();
        tick();
        sync = 2'b00;
        check("pre_rst_missed", {31'b0, missed}, 32'h1);
        check("pre_rst_tready", {31'b0, tready}, 32'h1);
        tvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_f_tready", {31'b0, tready}, 32'h0);
        check("rst_f_pat", pat, 32'h0);
        check("rst_f_missed", {31'b0, missed}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_tready", {31'b0, tready}, 32'h0);
        check("post_rst_pat", pat, 32'h0);
        tick();
        check("post_rst_pat2", pat, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wfg_drive_pat_core.md
WFG_DRIVE_PAT_CORE -- requirements
Module: wfg_drive_pat_core

Interface
REQ-001 SHALL have parameters: CHANNELS, default 32, number of pattern output pins; AXIS_W, default 32, stream data width (equal to CHANNELS).
REQ-002 SHALL have ports as listed here.
- clk  in  1  clock, rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- wfg_core_sync_i  in  2  one-cycle sync pulses from core 0 (bit 0) and core 1 (bit 1).
- wfg_axis_tdata_i  in  AXIS_W  stream pattern word.
- wfg_axis_tvalid_i  in  1  stream word valid.
- wfg_axis_tready_o  out  1  stream word accepted.
- ctrl_en_q_i  in  32  enable; only bit 0 used.
- cfg_core_sel_q_i  in  1  sync source select (0 = core 0, 1 = core 1).
- cfg_begin_q_i  in  8  first active pin index.
- cfg_end_q_i  in  8  last active pin index.
- patsel0_low_q_i  in  32  per-pin mode select, low bit.
- patsel1_high_q_i  in  32  per-pin mode select, high bit.
- wfg_pat_o  out  CHANNELS  registered pattern pins.
- wfg_pat_missed_o  out  1  sticky missed-sync flag.

Function
REQ-003 SHALL use sel_sync = wfg_core_sync_i[cfg_core_sel_q_i].
REQ-004 SHALL implement FSM states IDLE, ARMED, FETCH.
- IDLE -> ARMED when ctrl_en_q_i[0]=1.
- ARMED -> FETCH when sel_sync=1.
- FETCH -> ARMED on handshake (tvalid & tready).
REQ-005 SHALL force a transition to IDLE from any state in the cycle following ctrl_en_q_i[0]=0; this has priority over all other transitions.
REQ-006 SHALL drive wfg_axis_tready_o=1 only in state FETCH (decoded from registered state), otherwise 0.
REQ-007 SHALL, on handshake in FETCH, register the new wfg_pat_o value in the same edge.
- Latency: sync in cycle N, earliest handshake N+1, new wfg_pat_o visible N+2.
REQ-008 SHALL compute each pin i from mode {patsel1_high_q_i[i], patsel0_low_q_i[i]}:
- 00: drive 0.
- 01: drive 1.
- 10: drive tdata[i].
- 11: drive ~wfg_pat_o[i] (toggle on every update).
REQ-009 SHALL drive pin i to 0 at each update when i < cfg_begin_q_i or i > cfg_end_q_i, using unsigned 8-bit compares.
- If cfg_begin_q_i > cfg_end_q_i, all pins go to 0.
- Indices at or above CHANNELS are ignored.
REQ-010 SHALL sample configuration inputs only at the handshake edge; changes at any other time have no effect on wfg_pat_o.
REQ-011 SHALL hold wfg_pat_o stable between updates, including while in FETCH with wfg_axis_tvalid_i=0 (stall of unbounded length).
REQ-012 SHALL set wfg_pat_missed_o=1 when sel_sync=1 while in FETCH; the pending fetch continues and the extra sync is dropped (no queuing).
REQ-013 SHALL clear wfg_pat_missed_o and wfg_pat_o to 0 in the cycle following entry to IDLE; set on the same edge as a clear goes to clear.
REQ-014 SHALL ignore sync pulses in IDLE and in the enable cycle itself; the first accepted sync is one arriving while in ARMED.
REQ-015 SHALL ignore sync on the unselected core bit; a simultaneous pulse on both bits counts as one sync.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously force state=IDLE, wfg_pat_o=0, wfg_pat_missed_o=0, wfg_axis_tready_o=0.
REQ-017 SHALL resume from IDLE on the first rising clk edge after rst_n deasserts; reset asserted mid-FETCH drops the transfer without a handshake.

Verification
REQ-018 SHALL cover: en=1, begin=0, end=31, patsel0=0xFFFF0000, patsel1=0x0000FFFF, sync core0, tdata=0xA5A5A5A5 valid -> tready 1 cycle after sync, wfg_pat_o=0xFFFFA5A5 two cycles after sync.
REQ-019 SHALL cover: patsel0=patsel1=0xFFFFFFFF, begin=4, end=7, three syncs with data always valid -> wfg_pat_o sequence 0x000000F0, 0x00000000, 0x000000F0.
REQ-020 SHALL cover: tvalid held 0 for 10 cycles after sync, second sync in that window -> tready high throughout, wfg_pat_o unchanged, wfg_pat_missed_o=1, single update when tvalid rises.
REQ-021 SHALL cover: core_sel=1, pulses on core0 only -> no tready; pulse on core1 -> fetch occurs.
REQ-022 SHALL cover: begin=10, end=5, any data -> wfg_pat_o=0 after update.
REQ-023 SHALL cover: en dropped in FETCH, and separately rst_n pulsed low in FETCH -> tready=0, wfg_pat_o=0, wfg_pat_missed_o=0, no handshake counted.
